// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch state encoding, reset/halt constants and
// the byte-to-word address helper also used by i_mem.
package mips_pkg;

  typedef enum logic [1:0] {
    StRun,
    StHalt,
    StFault
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD = 32'h0000_000C;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  function automatic logic [31:0] word_addr(logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/if_slot.sv
// Registered valid/ready output slot carrying a fetched word to decode.
module if_slot (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    // Flush only drops valid; the payload is don't-care until the next load.
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and feeds
// decode through if_slot, handling redirects, back-pressure, halt and faults.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] HALT_WORD  = mips_pkg::HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted,
  output logic        fault
);

  import mips_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         slot_free;
  logic         pc_illegal;
  logic         slot_load;
  logic         slot_flush;

  assign imem_addr  = pc_q;
  assign slot_free  = !out_valid || out_ready;
  // The range check fires at pc = 4*IMEM_WORDS, long before pc+4 could wrap.
  assign pc_illegal = (pc_q[1:0] != 2'b00) || (word_addr(pc_q) >= IMEM_WORDS);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          slot_flush = 1'b1;
        end else if (slot_free) begin
          if (pc_illegal) begin
            state_d    = StFault;
            slot_flush = 1'b1;
          end else if (imem_instr == HALT_WORD) begin
            state_d    = StHalt;
            slot_flush = 1'b1;
          end else begin
            slot_load = 1'b1;
            pc_d      = pc_q + 32'd4;
          end
        end
      end
      StHalt, StFault: begin
      end
      default: begin
        state_d    = StFault;
        slot_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign halted = (state_q == StHalt);
  assign fault  = (state_q == StFault);

  if_slot u_if_slot (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (slot_load),
    .flush_i    (slot_flush),
    .instr_i    (imem_instr),
    .pc_i       (pc_q),
    .valid_o    (out_valid),
    .instr_o    (out_instr),
    .pc_o       (out_pc),
    .pc_plus4_o (out_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural fetch model.
module tb_fetch_ctrl;

  localparam logic [31:0] HaltWord = 32'h0000_000C;
  localparam int          Words    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        halted;
  logic        fault;

  logic [31:0] rom [Words];

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = running, 1 = halted, 2 = faulted.
  int          m_state;
  logic [31:0] m_pc, m_instr, m_opc, m_opc4;
  bit          m_valid;
  logic [31:0] obs_last_pc;

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr[31:8] == 24'd0) imem_instr = rom[imem_addr[7:2]];
    else                          imem_instr = 32'h0BAD_0BAD;
  end

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (Words),
    .HALT_WORD  (HaltWord)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .halted         (halted),
    .fault          (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    if (rst) begin
      m_state = 0; m_pc = 32'd0; m_valid = 1'b0;
      m_instr = 32'd0; m_opc = 32'd0; m_opc4 = 32'd0;
    end else if (m_state == 0) begin
      if (rv) begin
        m_pc    = rpc;
        m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        if ((m_pc % 4) != 0 || (m_pc / 4) >= Words) begin
          m_state = 2; m_valid = 1'b0;
        end else if (rom[m_pc[7:2]] == HaltWord) begin
          m_state = 1; m_valid = 1'b0;
        end else begin
          m_instr = rom[m_pc[7:2]];
          m_opc   = m_pc;
          m_opc4  = m_pc + 32'd4;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic compare(input bit rst);
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_state == 1});
    check("fault", {31'd0, fault}, {31'd0, m_state == 2});
    if (m_valid || rst) begin
      check("out_instr", out_instr, m_instr);
      check("out_pc", out_pc, m_opc);
      check("out_pc_plus4", out_pc_plus4, m_opc4);
    end
  endtask

  task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    model_step(rst, rv, rpc, rdy);
    @(posedge clk);
    #1;
    if (out_valid) obs_last_pc = out_pc;
    compare(rst);
  endtask

  task automatic load_program(input bit with_halt);
    for (int i = 0; i < Words; i++) begin
      rom[i] = $urandom;
      if (rom[i] == HaltWord) rom[i] = 32'h2000_0000;
    end
    rom[0] = 32'h2008_0001;
    rom[1] = 32'h2009_0002;
    rom[2] = 32'h0109_5020;
    rom[3] = with_halt ? HaltWord : 32'h0000_0020;
  endtask

  initial begin
    logic [31:0] tgt;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    obs_last_pc = 32'd0;
    load_program(1'b1);

    // Reset state
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // Straight-line run to the halt word
    cycle(0, 0, 0, 1); check("seq_pc0", out_pc, 32'h0);
    cycle(0, 0, 0, 1); check("seq_pc1", out_pc, 32'h4);
    cycle(0, 0, 0, 1); check("seq_pc2", out_pc, 32'h8);
    check("seq_pc2_plus4", out_pc_plus4, 32'hC);
    cycle(0, 0, 0, 1);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, out_valid}, 32'd0);
    check("halt_addr", imem_addr, 32'hC);
    cycle(0, 1, 32'h10, 1);
    check("halt_ignores_redirect", imem_addr, 32'hC);

    // Back-pressure
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      check("bp_instr", out_instr, 32'h2008_0001);
      check("bp_pc", out_pc, 32'h0);
      check("bp_addr", imem_addr, 32'h4);
    end
    cycle(0, 0, 0, 1);
    check("bp_release", out_instr, 32'h2009_0002);

    // Redirect while stalled, then misaligned redirect
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h10, 0);
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    cycle(0, 0, 0, 1);
    check("redir_pc", out_pc, 32'h10);
    check("redir_instr", out_instr, rom[4]);
    cycle(0, 1, 32'h102, 1);
    check("mis_load", imem_addr, 32'h102);
    check("mis_nofault_yet", {31'd0, fault}, 32'd0);
    cycle(0, 0, 0, 1);
    check("mis_fault", {31'd0, fault}, 32'd1);
    cycle(0, 1, 32'h20, 1);
    check("fault_ignores_redirect", imem_addr, 32'h102);

    // Run off the end of the ROM
    load_program(1'b0);
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 66; i++) cycle(0, 0, 0, 1);
    check("range_fault", {31'd0, fault}, 32'd1);
    check("range_last_pc", obs_last_pc, 32'hFC);
    check("range_addr", imem_addr, 32'h100);

    // Reset out of HALT and mid-stream
    load_program(1'b1);
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    check("pre_rst_halt", {31'd0, halted}, 32'd1);
    cycle(1, 0, 0, 1);
    check("rst_halt_clear", {31'd0, halted}, 32'd0);
    cycle(0, 0, 0, 1);
    check("restart_pc", out_pc, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_instr", out_instr, 32'd0);
    cycle(0, 0, 0, 1);
    check("restart_instr", out_instr, 32'h2008_0001);

    // Randomized traffic against the model
    for (int i = 0; i < Words; i++) begin
      rom[i] = ($urandom_range(0, 47) == 0) ? HaltWord : $urandom;
    end
    cycle(1, 0, 0, 1);
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 15))
        0:       tgt = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        1:       tgt = 32'($urandom_range(64, 200)) << 2;
        default: tgt = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, tgt,
            $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
